// File: rtl/fpgalink_pkg.sv
// Shared definitions for the FX2 host-protocol engine: FSM states,
// endpoint addresses and command field layout.
package fpgalink_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CNT0,
      S_CNT1,
      S_CNT2,
      S_CNT3,
      S_WRITE,
      S_READ,
      S_FLUSH
   } state_t;

   localparam logic [1:0] EP_OUT = 2'b00;  // EP2 OUT: host -> FPGA
   localparam logic [1:0] EP_IN  = 2'b10;  // EP6 IN:  FPGA -> host

   localparam int CMD_DIR_BIT = 7;         // 1 = read (f2h), 0 = write (h2f)
   localparam int CHAN_W      = 7;
   localparam int COUNT_W     = 32;

endpackage

// File: rtl/fpgalink_fx2_comm.sv
// FX2 slave-FIFO protocol engine: parses a 5-byte host command
// (dir/channel, 32-bit big-endian count) and streams bytes between the
// FX2 FIFOs and the application channel bus, flushing short IN packets.
module fpgalink_fx2_comm
   import fpgalink_pkg::*;
#(
   parameter int EP_SIZE = 512
) (
   input  logic              IFCLK,
   input  logic              RST,
   input  logic [7:0]        FDI,
   output logic [7:0]        FDO,
   output logic              FDS,
   output logic              SLRD,
   output logic              SLOE,
   output logic              SLWR,
   output logic [1:0]        ADDR,
   input  logic              FLAGB,
   input  logic              FLAGC,
   output logic              PKTEND,
   output logic [CHAN_W-1:0] chan_addr,
   output logic [7:0]        h2f_data,
   output logic              h2f_valid,
   input  logic              h2f_ready,
   input  logic [7:0]        f2h_data,
   input  logic              f2h_valid,
   output logic              f2h_ready
);

   localparam int PKT_W = $clog2(EP_SIZE);

   state_t              state, state_nx;
   logic [COUNT_W-1:0]  count, count_nx, count_sh;
   logic [PKT_W-1:0]    pkt_cnt, pkt_nx, pkt_inc;
   logic [CHAN_W-1:0]   chan_nx;
   logic                dir, dir_nx;
   // Low for the edge of reset and the cycle after it, so the strobes sit at
   // their reset values while RST is asserted rather than following S_IDLE.
   logic                active;

   assign h2f_data = FDI;
   assign FDO      = f2h_data;
   assign count_sh = {count[COUNT_W-9:0], FDI};
   assign pkt_inc  = pkt_cnt + PKT_W'(1);

   // State register and datapath registers, synchronous active-low reset.
   always_ff @(posedge IFCLK) begin
      if (!RST) begin
         active    <= 1'b0;
         state     <= S_IDLE;
         count     <= '0;
         pkt_cnt   <= '0;
         chan_addr <= '0;
         dir       <= 1'b0;
      end else begin
         active    <= 1'b1;
         state     <= state_nx;
         count     <= count_nx;
         pkt_cnt   <= pkt_nx;
         chan_addr <= chan_nx;
         dir       <= dir_nx;
      end
   end

   // Next-state logic and combinational FIFO strobes/handshakes.
   always_comb begin
      state_nx  = state;
      count_nx  = count;
      pkt_nx    = pkt_cnt;
      chan_nx   = chan_addr;
      dir_nx    = dir;
      ADDR      = EP_OUT;
      SLOE      = 1'b1;
      SLRD      = 1'b1;
      SLWR      = 1'b1;
      PKTEND    = 1'b1;
      FDS       = 1'b0;
      h2f_valid = 1'b0;
      f2h_ready = 1'b0;
      if (active) begin
         case (state)
            S_IDLE: begin
               SLOE = 1'b0;
               SLRD = !FLAGC;
               if (FLAGC) begin
                  chan_nx  = FDI[CHAN_W-1:0];
                  dir_nx   = FDI[CMD_DIR_BIT];
                  state_nx = S_CNT0;
               end
            end
            S_CNT0, S_CNT1, S_CNT2: begin
               SLOE = 1'b0;
               SLRD = !FLAGC;
               if (FLAGC) begin
                  count_nx = count_sh;
                  state_nx = (state == S_CNT0) ? S_CNT1 :
                             (state == S_CNT1) ? S_CNT2 : S_CNT3;
               end
            end
            S_CNT3: begin
               SLOE = 1'b0;
               SLRD = !FLAGC;
               if (FLAGC) begin
                  count_nx = count_sh;
                  if (count_sh == '0) begin
                     state_nx = S_IDLE;
                  end else if (dir) begin
                     state_nx = S_READ;
                     pkt_nx   = '0;
                  end else begin
                     state_nx = S_WRITE;
                  end
               end
            end
            S_WRITE: begin
               SLOE      = 1'b0;
               h2f_valid = FLAGC;
               SLRD      = !(FLAGC & h2f_ready);
               if (FLAGC & h2f_ready) begin
                  count_nx = count - COUNT_W'(1);
                  if (count == COUNT_W'(1))
                     state_nx = S_IDLE;
               end
            end
            S_READ: begin
               ADDR      = EP_IN;
               FDS       = 1'b1;
               f2h_ready = FLAGB;
               SLWR      = !(FLAGB & f2h_valid);
               if (FLAGB & f2h_valid) begin
                  count_nx = count - COUNT_W'(1);
                  pkt_nx   = pkt_inc;
                  // A full packet ends exactly on the last byte: nothing to flush.
                  if (count == COUNT_W'(1))
                     state_nx = (pkt_inc == '0) ? S_IDLE : S_FLUSH;
               end
            end
            S_FLUSH: begin
               ADDR   = EP_IN;
               PKTEND = !FLAGB;
               if (FLAGB)
                  state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fpgalink_fx2_comm.sv
// Directed bench for fpgalink_fx2_comm: a byte-level protocol model checks
// every output each cycle; per-test strobe/beat totals pin the model.
module tb_fpgalink_fx2_comm;

   localparam int EP = 512;

   logic       IFCLK = 1'b0;
   logic       RST = 1'b0;
   logic [7:0] FDI = 8'h00;
   logic [7:0] FDO;
   logic       FDS, SLRD, SLOE, SLWR, PKTEND;
   logic [1:0] ADDR;
   logic       FLAGB = 1'b0;
   logic       FLAGC = 1'b0;
   logic [6:0] chan_addr;
   logic [7:0] h2f_data;
   logic       h2f_valid;
   logic       h2f_ready = 1'b0;
   logic [7:0] f2h_data = 8'h00;
   logic       f2h_valid = 1'b0;
   logic       f2h_ready;

   fpgalink_fx2_comm #(.EP_SIZE(EP)) dut (
      .IFCLK(IFCLK), .RST(RST), .FDI(FDI), .FDO(FDO), .FDS(FDS),
      .SLRD(SLRD), .SLOE(SLOE), .SLWR(SLWR), .ADDR(ADDR),
      .FLAGB(FLAGB), .FLAGC(FLAGC), .PKTEND(PKTEND), .chan_addr(chan_addr),
      .h2f_data(h2f_data), .h2f_valid(h2f_valid), .h2f_ready(h2f_ready),
      .f2h_data(f2h_data), .f2h_valid(f2h_valid), .f2h_ready(f2h_ready)
   );

   always #5 IFCLK = ~IFCLK;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Protocol model: phase 0 = collecting header bytes, 1 = write stream,
   // 2 = read stream, 3 = waiting to flush a short packet.
   int              mphase = 0;
   int              hdr_n = 0;
   logic [7:0]      hdr [5];
   longint unsigned remaining = 0;
   longint unsigned sent = 0;
   logic [6:0]      mchan = '0;
   bit              mactive = 0;
   bit              mvalid = 0;

   // Event totals observed on the DUT pins, used by the literal checks.
   int         n_slrd = 0, n_slwr = 0, n_pktend = 0, n_h2f = 0;
   logic [7:0] h2f_log [64];

   // Compare process: check outputs mid-cycle, then advance the model with
   // the inputs that the coming rising edge will sample.
   always @(negedge IFCLK) begin
      logic       e_slrd, e_sloe, e_slwr, e_pktend, e_fds, e_h2fv, e_f2hr;
      logic [1:0] e_addr;
      e_slrd = 1; e_sloe = 1; e_slwr = 1; e_pktend = 1;
      e_fds = 0; e_h2fv = 0; e_f2hr = 0; e_addr = 2'b00;
      if (mactive) begin
         case (mphase)
            0: begin e_sloe = 0; e_slrd = !FLAGC; end
            1: begin e_sloe = 0; e_h2fv = FLAGC; e_slrd = !(FLAGC && h2f_ready); end
            2: begin e_addr = 2'b10; e_fds = 1; e_f2hr = FLAGB; e_slwr = !(FLAGB && f2h_valid); end
            default: begin e_addr = 2'b10; e_pktend = !FLAGB; end
         endcase
      end
      if (mvalid) begin
         chk("SLRD", SLRD, e_slrd);
         chk("SLOE", SLOE, e_sloe);
         chk("SLWR", SLWR, e_slwr);
         chk("PKTEND", PKTEND, e_pktend);
         chk("FDS", FDS, e_fds);
         chk("ADDR", ADDR, e_addr);
         chk("h2f_valid", h2f_valid, e_h2fv);
         chk("f2h_ready", f2h_ready, e_f2hr);
         chk("chan_addr", chan_addr, mchan);
         chk("h2f_data", h2f_data, FDI);
         if (e_fds) chk("FDO", FDO, f2h_data);
      end
      if (!SLRD) n_slrd++;
      if (!SLWR) n_slwr++;
      if (!PKTEND) n_pktend++;
      if (h2f_valid && h2f_ready) begin
         h2f_log[n_h2f % 64] = h2f_data;
         n_h2f++;
      end
      if (!RST) begin
         mactive = 0; mvalid = 1; mphase = 0; hdr_n = 0;
         remaining = 0; sent = 0; mchan = '0;
      end else if (!mactive) begin
         mactive = 1;
      end else begin
         case (mphase)
            0: if (FLAGC) begin
               hdr[hdr_n] = FDI;
               if (hdr_n == 0) mchan = FDI[6:0];
               hdr_n++;
               if (hdr_n == 5) begin
                  hdr_n = 0;
                  remaining = {32'd0, hdr[1], hdr[2], hdr[3], hdr[4]};
                  if (remaining == 0) mphase = 0;
                  else if (hdr[0][7]) begin mphase = 2; sent = 0; end
                  else mphase = 1;
               end
            end
            1: if (FLAGC && h2f_ready) begin
               remaining--;
               if (remaining == 0) mphase = 0;
            end
            2: if (FLAGB && f2h_valid) begin
               remaining--;
               sent++;
               if (remaining == 0) mphase = (sent % EP == 0) ? 0 : 3;
            end
            default: if (FLAGB) mphase = 0;
         endcase
      end
   end

   logic [7:0] cmd [8];

   task automatic idle(input int n);
      repeat (n) begin @(posedge IFCLK); #1; end
   endtask

   // Present cmd[0..n-1] on FDI, advancing whenever the DUT pops (SLRD low).
   task automatic feed(input int n, input int toggle_ready);
      int  idx = 0;
      int  cyc = 0;
      bit  pop;
      while (idx < n && cyc < 200) begin
         FDI = cmd[idx];
         FLAGC = 1'b1;
         h2f_ready = (toggle_ready == 0) ? 1'b1 : ((cyc % 2) == 0);
         @(negedge IFCLK);
         pop = !SLRD;
         @(posedge IFCLK); #1;
         if (pop) idx++;
         cyc++;
      end
      chk("feed_progress", idx, n);
      FLAGC = 1'b0;
   endtask

   // Stream read bytes for n cycles with FLAGB from the given schedule mode.
   task automatic stream(input int n, input int mode);
      bit beat;
      for (int i = 0; i < n; i++) begin
         f2h_valid = 1'b1;
         if (mode == 1) FLAGB = (i < 2) || (i == 5) || (i == 6) || (i >= 9);
         else FLAGB = 1'b1;
         @(negedge IFCLK);
         beat = !SLWR;
         @(posedge IFCLK); #1;
         if (beat) f2h_data = f2h_data + 8'h01;
      end
      f2h_valid = 1'b0;
      FLAGB = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   int s0, w0, p0, h0;

   initial begin
      idle(3);
      chk("rst_SLOE", SLOE, 1);
      chk("rst_SLRD", SLRD, 1);
      chk("rst_FDS", FDS, 0);
      chk("rst_chan", chan_addr, 0);
      RST = 1'b1;
      idle(2);

      // Write ch 5, 3 bytes, ready always high
      s0 = n_slrd; h0 = n_h2f;
      cmd = '{8'h05, 8'h00, 8'h00, 8'h00, 8'h03, 8'hAA, 8'hBB, 8'hCC};
      feed(8, 0); idle(3);
      chk("w1_slrd_cnt", n_slrd - s0, 8);
      chk("w1_beats", n_h2f - h0, 3);
      chk("w1_b0", h2f_log[h0 % 64], 8'hAA);
      chk("w1_b1", h2f_log[(h0 + 1) % 64], 8'hBB);
      chk("w1_b2", h2f_log[(h0 + 2) % 64], 8'hCC);
      chk("w1_chan", chan_addr, 7'h05);

      // Same write, ready toggling
      s0 = n_slrd; h0 = n_h2f;
      feed(8, 1); idle(3);
      chk("w2_slrd_cnt", n_slrd - s0, 8);
      chk("w2_beats", n_h2f - h0, 3);
      chk("w2_b0", h2f_log[h0 % 64], 8'hAA);
      chk("w2_b1", h2f_log[(h0 + 1) % 64], 8'hBB);
      chk("w2_b2", h2f_log[(h0 + 2) % 64], 8'hCC);

      // Read ch 0x12, 4 bytes: short packet flushed once
      cmd = '{8'h92, 8'h00, 8'h00, 8'h00, 8'h04, 8'h00, 8'h00, 8'h00};
      w0 = n_slwr; p0 = n_pktend;
      feed(5, 0); stream(12, 0); idle(2);
      chk("r1_slwr_cnt", n_slwr - w0, 4);
      chk("r1_pktend_cnt", n_pktend - p0, 1);
      chk("r1_chan", chan_addr, 7'h12);

      // Read exactly one full packet: no flush
      cmd = '{8'h92, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00, 8'h00};
      w0 = n_slwr; p0 = n_pktend;
      feed(5, 0); stream(530, 0); idle(2);
      chk("r2_slwr_cnt", n_slwr - w0, 512);
      chk("r2_pktend_cnt", n_pktend - p0, 0);

      // Read 4 with FLAGB gaps mid-stream and on flush entry
      cmd = '{8'h92, 8'h00, 8'h00, 8'h00, 8'h04, 8'h00, 8'h00, 8'h00};
      w0 = n_slwr; p0 = n_pktend;
      feed(5, 0); stream(9, 1);
      chk("r3_pktend_wait", n_pktend - p0, 0);
      chk("r3_slwr_cnt", n_slwr - w0, 4);
      FLAGB = 1'b1; f2h_valid = 1'b1;
      idle(3);
      FLAGB = 1'b0; f2h_valid = 1'b0;
      chk("r3_pktend_cnt", n_pktend - p0, 1);
      chk("r3_slwr_total", n_slwr - w0, 4);

      // Zero-length write
      cmd = '{8'h05, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
      s0 = n_slrd; h0 = n_h2f;
      feed(5, 0); idle(3);
      chk("z_slrd_cnt", n_slrd - s0, 5);
      chk("z_beats", n_h2f - h0, 0);

      // Reset mid-write after 1 of 3 bytes
      cmd = '{8'h05, 8'h00, 8'h00, 8'h00, 8'h03, 8'hAA, 8'h00, 8'h00};
      feed(6, 0);
      RST = 1'b0; FLAGC = 1'b1; FDI = 8'hBB; h2f_ready = 1'b1;
      @(posedge IFCLK); #1;
      chk("mid_rst_SLRD", SLRD, 1);
      chk("mid_rst_SLOE", SLOE, 1);
      chk("mid_rst_h2fv", h2f_valid, 0);
      chk("mid_rst_chan", chan_addr, 0);
      idle(1);
      RST = 1'b1; FLAGC = 1'b0;
      idle(2);
      cmd = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h01, 8'h55, 8'h00, 8'h00};
      h0 = n_h2f;
      feed(6, 0); idle(3);
      chk("post_rst_beats", n_h2f - h0, 1);
      chk("post_rst_b0", h2f_log[h0 % 64], 8'h55);
      chk("post_rst_chan", chan_addr, 7'h01);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
